// File: rtl/tdm_demux4.sv
//----------------------------------------------------------------------------
// tdm_demux4 : serial 4-channel TDM demultiplexer with frame-sync tracking.
// Optional build macro TDM_DEMUX_PARITY_EN adds a 5th even-parity slot.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tdm_demux4 #(
  parameter int SYNC_LOSS = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  input  logic ivalid,
  input  logic fsync,
  output logic y0,
  output logic y1,
  output logic y2,
  output logic y3,
  output logic s1,
  output logic s0,
  output logic frame_valid,
  output logic sync_err,
  output logic parity_err,
  output logic locked
);

`ifdef TDM_DEMUX_PARITY_EN
  localparam int                 CNT_W     = 3;
  localparam logic [CNT_W-1:0]   LAST_SLOT = 3'd4;
`else
  localparam int                 CNT_W     = 2;
  localparam logic [CNT_W-1:0]   LAST_SLOT = 2'd3;
`endif

  localparam logic [2:0] LOSS = 3'(SYNC_LOSS);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] LOCK = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] slot_cnt;
  logic [2:0]       err_cnt;
  logic [2:0]       err_inc;
  logic [3:0]       shadow;
  logic [3:0]       shadow_nxt;
  logic [3:0]       y;
  logic             frame_err;
  logic             loss;
  logic             parity_ok;

  // Shadow with the incoming bit merged at the current slot; slot 4 (parity) is not stored.
  always_comb begin
    shadow_nxt = shadow;
    for (int k = 0; k < 4; k++) begin
      if (slot_cnt == CNT_W'(k)) begin
        shadow_nxt[k] = i;
      end
    end
  end

  assign frame_err = (fsync && (slot_cnt != '0)) || (!fsync && (slot_cnt == '0));
  assign err_inc   = err_cnt + 3'd1;
  assign loss      = (err_inc == LOSS);

`ifdef TDM_DEMUX_PARITY_EN
  assign parity_ok = ~(^shadow ^ i);
`else
  assign parity_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= HUNT;
      slot_cnt    <= '0;
      err_cnt     <= '0;
      shadow      <= '0;
      y           <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err  <= 1'b0;
`endif
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
      parity_err  <= 1'b0;
`endif
      if (ivalid) begin
        if (state == HUNT) begin
          if (fsync) begin
            shadow   <= {3'b000, i};
            slot_cnt <= CNT_W'(1);
            state    <= LOCK;
          end
        end else if (frame_err) begin
          sync_err <= 1'b1;
          if (loss) begin
            state    <= HUNT;
            err_cnt  <= '0;
            slot_cnt <= '0;
            shadow   <= '0;
          end else begin
            err_cnt <= err_inc;
            // A misplaced fsync is trusted as the start of a fresh frame.
            if (fsync) begin
              shadow   <= {3'b000, i};
              slot_cnt <= CNT_W'(1);
            end else begin
              shadow   <= '0;
              slot_cnt <= '0;
            end
          end
        end else if (slot_cnt == LAST_SLOT) begin
          shadow   <= shadow_nxt;
          slot_cnt <= '0;
          if (parity_ok) begin
            y           <= shadow_nxt;
            frame_valid <= 1'b1;
            err_cnt     <= '0;
          end else begin
`ifdef TDM_DEMUX_PARITY_EN
            parity_err  <= 1'b1;
`endif
          end
        end else begin
          shadow   <= shadow_nxt;
          slot_cnt <= slot_cnt + CNT_W'(1);
        end
      end
    end
  end

`ifndef TDM_DEMUX_PARITY_EN
  assign parity_err = 1'b0;
`endif

  assign {y3, y2, y1, y0} = y;
  assign {s1, s0}         = slot_cnt[1:0];
  assign locked           = (state == LOCK);

endmodule

`default_nettype wire

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4; expected frames are queued as slots are driven
// and popped when frame_valid is due.
`default_nettype none

module tb_tdm_demux4;

`ifdef TDM_DEMUX_PARITY_EN
  localparam int NS = 5;
`else
  localparam int NS = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i = 1'b0;
  logic ivalid = 1'b0;
  logic fsync = 1'b0;
  logic y0, y1, y2, y3, s1, s0, frame_valid, sync_err, parity_err, locked;

  int checks = 0;
  int failures = 0;
  logic [3:0] exp_q[$];
  logic [3:0] cur_y = 4'b0000;

  tdm_demux4 #(.SYNC_LOSS(2)) dut (
    .clk(clk), .rst(rst), .i(i), .ivalid(ivalid), .fsync(fsync),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3), .s1(s1), .s0(s0),
    .frame_valid(frame_valid), .sync_err(sync_err),
    .parity_err(parity_err), .locked(locked)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one cycle, then compare every output just after the edge.
  task automatic step(input logic v, input logic b, input logic f,
                      input logic efv, input logic ese, input logic epe,
                      input logic [1:0] es, input logic elk);
    ivalid = v;
    i      = b;
    fsync  = f;
    @(posedge clk);
    #1;
    if (efv && exp_q.size() > 0) cur_y = exp_q.pop_front();
    check("frame_valid", {7'd0, frame_valid}, {7'd0, efv});
    check("sync_err",    {7'd0, sync_err},    {7'd0, ese});
    check("parity_err",  {7'd0, parity_err},  {7'd0, epe});
    check("slot",        {6'd0, s1, s0},      {6'd0, es});
    check("locked",      {7'd0, locked},      {7'd0, elk});
    check("y",           {4'd0, y3, y2, y1, y0}, {4'd0, cur_y});
  endtask

  // Slots 1..3 (plus parity) of a good frame whose slot 0 is already accepted.
  task automatic frame_tail(input logic [3:0] d, input bit gaps);
    for (int k = 1; k < 4; k++) begin
      if (k == 3 && NS == 4) exp_q.push_back(d);
      step(1'b1, d[k], 1'b0, (k == 3 && NS == 4), 1'b0, 1'b0, 2'((k + 1) % NS), 1'b1);
      if (gaps) step(1'b0, ~d[k], 1'b1, 1'b0, 1'b0, 1'b0, 2'((k + 1) % NS), 1'b1);
    end
`ifdef TDM_DEMUX_PARITY_EN
    exp_q.push_back(d);
    step(1'b1, ^d, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b1);
    if (gaps) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
`endif
  endtask

  task automatic frame(input logic [3:0] d, input bit gaps);
    step(1'b1, d[0], 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    if (gaps) step(1'b0, ~d[0], 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    frame_tail(d, gaps);
  endtask

  initial begin
    // Reset, including priority of rst over an accepted fsync.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;

    // Slots carry 1,0,1,0; d[k] is slot k.
    frame(4'b0101, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

    // 1,1,0,0 with ivalid gaps between slots.
    frame(4'b0011, 1'b1);

    // fsync at slot 2 restarts the frame as slot 0.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd1, 1'b1);
    frame_tail(4'b1001, 1'b0);

    // Two missing slot-0 fsyncs drop lock; no frame until the next fsync.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    frame(4'b0110, 1'b0);

    // Reset in the middle of a frame.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    rst   = 1'b1;
    cur_y = 4'b0000;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
    rst = 1'b0;
    frame(4'b0111, 1'b0);

`ifdef TDM_DEMUX_PARITY_EN
    // 1,0,1,0 with a wrong parity bit, then with the right one.
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b1);
    frame(4'b0101, 1'b0);
`endif

    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
